button_pio_in: RTL and testbench
================================

// Module: button_pio_in
// PURPOSE
// - Avalon-MM input PIO slave feeding push-button/switch state into the Nios II system. It is the
//   input-direction counterpart of the LED output PIO.
// - Synchronises and debounces asynchronous buttons, and latches press events in an edge-capture register.
// - Raises a maskable, level-sensitive irq to the CPU.
// - Register map matches the standard PIO layout, so existing HAL drivers work unchanged.
// PARAMETERS
// - WIDTH           4       number of button inputs (1..32)
// - DEBOUNCE_CYCLES 250000  cycles an input must hold a new level before it is accepted (5 ms @ 50 MHz)
// - ACTIVE_LOW      1       1: pressed = 0 on pin; 0: pressed = 1
// PORTS
// - clk           in   1      system clock; single clock domain
// - rst           in   1      synchronous reset, active-high
// - button_in     in   WIDTH  raw asynchronous button pins
// - avs_address   in   2      word address: 0 data, 1 direction, 2 irqmask, 3 edgecapture
// - avs_read      in   1      read strobe
// - avs_write     in   1      write strobe
// - avs_writedata in   32     write data
// - avs_readdata  out  32     read data, registered
// - irq           out  1      interrupt request, level, active-high
// BEHAVIOUR
// - Reset (rst=1 at a clk edge) forces all state to defaults:
//   - avs_readdata=0, irq=0, irqmask=0, edgecapture=0, debounce counters=0.
//   - Both sync flops and the stable level load the RELEASED level (all 1s if ACTIVE_LOW, else all 0s),
//     so leaving reset never produces a false press.
//   - Reset asserted mid-debounce or mid-read aborts the operation; no capture survives.
// - Input path, per bit:
//   - 2-flop synchroniser feeds sync[i].
//   - If sync[i]==stable[i]: cnt[i]<=0.
//   - Else if cnt[i]==DEBOUNCE_CYCLES-1: stable[i]<=sync[i] and cnt[i]<=0.
//   - Else cnt[i]<=cnt[i]+1.
//   - Counter width = $clog2(DEBOUNCE_CYCLES); it never wraps.
//   - Any bounce back to the stable level restarts the count.
//   - Minimum pin-to-stable latency = 2 + DEBOUNCE_CYCLES cycles.
// - Press detect: press[i] pulses 1 cycle when stable[i] goes released -> pressed. Release sets nothing.
// - Data register (read 0): bit i = 1 when button i is pressed after debounce, for either ACTIVE_LOW value.
// - Register reads and writes:
//   - Reads return 0 in bits 31:WIDTH.
//   - Writes to address 0 are ignored.
//   - Address 1 reads 0 and ignores writes (input-only port).
//   - irqmask (addr 2) is R/W in bits WIDTH-1:0.
//   - edgecapture (addr 3) is read, write-1-to-clear.
// - edgecapture: press[i] sets bit i.
//   - Same cycle as a W1C of bit i: the set wins and the bit stays 1.
// - Read timing:
//   - avs_readdata is valid the cycle after avs_read (fixed read latency 1) and holds until the next read.
//   - avs_read and avs_write asserted in the same cycle: the write takes effect and the read returns
//     pre-write contents.
//   - No waitrequest; the slave accepts every transfer.
// - irq is registered: irq <= |(edgecapture & irqmask). It deasserts 1 cycle after the clearing write.
// STRUCTURE
// - Package button_pio_pkg holds:
//   - address constants ADDR_DATA=2'd0, ADDR_DIR=2'd1, ADDR_IRQMASK=2'd2, ADDR_EDGE=2'd3;
//   - the read-data zero-extension helper.
// - Sub-module debounce_bit (params DEBOUNCE_CYCLES and RELEASED; ports clk, rst, din, stable, press) holds
//   the synchroniser, counter and press pulse. It is instantiated WIDTH times via generate.
// - Top level holds the register file, the read mux and the irq.
// TESTING (use DEBOUNCE_CYCLES=8 for sim)
// - Reset, buttons idle (all 1s) -> read addr0 = 0x0, addr3 = 0x0, irq=0; no edge after rst drops.
// - Clean press: bit0 low for 20 cycles -> stable changes exactly 10 cycles after pin edge;
//   addr0 = 0x1, addr3 = 0x1.
// - Bounce: bit1 toggles every 5 cycles for 40 cycles, then holds low -> one capture only;
//   addr3 = 0x2, set 10 cycles after final edge.
// - irq: write addr2 = 0x1, press bit0 -> irq=1 one cycle after capture; write addr3 = 0x1 ->
//   irq=0 next cycle; press bit2 with mask 0x1 -> irq stays 0.
// - Set/clear collision: W1C 0x4 on the same cycle as the press[2] pulse -> addr3 bit2 reads 1.
// - Reset mid-debounce: pin low for 5 cycles, rst for 1 cycle, pin stays low -> capture exactly
//   10 cycles after rst drops; addr1 always reads 0; writes to addr0 ignored.

Source files
------------

// File: rtl/button_pio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_pio_pkg
// Description : Shared constants and helpers for the button input PIO.
//               Holds the Avalon-MM word addresses of the standard PIO layout
//               and the read-data zero-extension helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package button_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_DIR     = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE    = 2'd3;

  // Clears every bit at or above 'width' so unused register bits read as 0.
  function automatic logic [31:0] rd_zext(input logic [31:0] value,
                                          input int unsigned width);
    logic [31:0] keep;
    keep = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return value & keep;
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// ============================================================================
// Module      : debounce_bit
// Description : One button channel: 2-flop synchroniser, hold-time debounce
//               counter and a one-cycle press pulse.
// Ports       : clk    - system clock
//               rst    - synchronous reset, active-high
//               din    - raw asynchronous pin
//               stable - debounced pin level (pin polarity, not "pressed")
//               press  - high for the single cycle in which stable moves
//                        from RELEASED to the pressed level
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_bit #(
  parameter int   DEBOUNCE_CYCLES = 250000,
  parameter logic RELEASED        = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic stable,
  output logic press
);

  localparam int             CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic          stable_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          accept;

  // Counter only runs while the synchronised pin disagrees with the accepted
  // level; any return to the accepted level restarts it from zero.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      accept   = 1'b1;
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Combinational so the capture register sets on the same edge that
  // stable changes.
  assign press  = accept && (sync2_q != RELEASED);
  assign stable = stable_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Loading the released level keeps reset exit from looking like a press.
      sync1_q  <= RELEASED;
      sync2_q  <= RELEASED;
      stable_q <= RELEASED;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= din;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/button_pio_in.sv
`default_nettype none
// ============================================================================
// Module      : button_pio_in
// Description : Avalon-MM input PIO for push-buttons/switches. Debounces each
//               pin, latches presses in a W1C edge-capture register and
//               raises a maskable level interrupt. Standard PIO register map.
// Ports       : clk, rst                - clock, synchronous active-high reset
//               button_in[WIDTH]        - raw asynchronous pins
//               avs_address/read/write/writedata - Avalon-MM slave, no waitrequest
//               avs_readdata[32]        - registered read data, latency 1
//               irq                     - level interrupt, active-high
// Revision    : 1.0 - initial release
// ============================================================================
module button_pio_in
  import button_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] button_in,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq
);

  logic [WIDTH-1:0] stable_w;
  logic [WIDTH-1:0] press_w;
  logic [WIDTH-1:0] pressed_w;

  logic [WIDTH-1:0] irqmask_q;
  logic [WIDTH-1:0] irqmask_d;
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] edge_d;
  logic [31:0]      readdata_q;
  logic [31:0]      readdata_d;
  logic             irq_q;
  logic             irq_d;
  logic [31:0]      rd_mux;
  logic [WIDTH-1:0] clr_mask;

  // Write data above WIDTH has no destination.
  logic unused_wdata;
  assign unused_wdata = ^avs_writedata;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      debounce_bit #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RELEASED        (ACTIVE_LOW)
      ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .din    (button_in[gi]),
        .stable (stable_w[gi]),
        .press  (press_w[gi])
      );
    end
  endgenerate

  // Data register reports "pressed" as 1 regardless of pin polarity.
  assign pressed_w = ACTIVE_LOW ? ~stable_w : stable_w;

  always_comb begin
    irqmask_d = irqmask_q;
    clr_mask  = '0;
    if (avs_write && (avs_address == ADDR_IRQMASK)) begin
      irqmask_d = avs_writedata[WIDTH-1:0];
    end
    if (avs_write && (avs_address == ADDR_EDGE)) begin
      clr_mask = avs_writedata[WIDTH-1:0];
    end
    // OR-ing the press last lets a simultaneous set beat the clear.
    edge_d = (edge_q & ~clr_mask) | press_w;

    // Mux uses pre-write register contents, so read+write returns old data.
    case (avs_address)
      ADDR_DATA:    rd_mux = 32'(pressed_w);
      ADDR_DIR:     rd_mux = 32'd0;
      ADDR_IRQMASK: rd_mux = 32'(irqmask_q);
      ADDR_EDGE:    rd_mux = 32'(edge_q);
      default:      rd_mux = 32'd0;
    endcase
    readdata_d = avs_read ? rd_zext(rd_mux, WIDTH) : readdata_q;

    irq_d = |(edge_q & irqmask_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irqmask_q  <= '0;
      edge_q     <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      irqmask_q  <= irqmask_d;
      edge_q     <= edge_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign avs_readdata = readdata_q;
  assign irq          = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_button_pio_in.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_pio_in
// Description : Self-checking bench for button_pio_in (WIDTH=4,
//               DEBOUNCE_CYCLES=8, ACTIVE_LOW=1). Directed scenarios followed
//               by randomized traffic; a reference model predicts read data
//               and irq, a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_pio_in;

  localparam int         W   = 4;
  localparam int         D   = 8;
  localparam logic [3:0] REL = 4'hF;

  logic        clk;
  logic        rst;
  logic [3:0]  button_in;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        irq;

  button_pio_in #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (D),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .button_in     (button_in),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .irq           (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] exp_q[$];
  logic        rd_pend = 1'b0;
  logic        irq_exp = 1'b0;
  logic        const_valid = 1'b0;
  logic [31:0] const_val = '0;

  logic [3:0]  m_pin_d1;     // pin as seen one edge ago
  logic [3:0]  m_pin_d2;     // pin as seen two edges ago (what the filter judges)
  logic [3:0]  m_level;      // accepted pin level
  int          m_held [4];   // consecutive cycles the judged pin differed from m_level
  logic [3:0]  m_edge;
  logic [3:0]  m_mask;

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, ~m_level};
      2'd2:    return {28'd0, m_mask};
      2'd3:    return {28'd0, m_edge};
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_pin_d1 = REL;
        m_pin_d2 = REL;
        m_level  = REL;
        for (int i = 0; i < 4; i++) m_held[i] = 0;
        m_edge  = '0;
        m_mask  = '0;
        irq_exp = 1'b0;
        rd_pend = 1'b0;
        exp_q.delete();
      end else begin
        logic [3:0] presses;
        logic [3:0] old_edge;
        logic [3:0] old_mask;
        old_edge = m_edge;
        old_mask = m_mask;
        if (avs_read) exp_q.push_back(const_valid ? const_val : model_read(avs_address));
        rd_pend = avs_read;
        presses = '0;
        // A new level is accepted once it has been seen for D straight cycles.
        for (int i = 0; i < 4; i++) begin
          if (m_pin_d2[i] != m_level[i]) begin
            m_held[i] = m_held[i] + 1;
            if (m_held[i] == D) begin
              m_level[i] = m_pin_d2[i];
              m_held[i]  = 0;
              if (m_level[i] == 1'b0) presses[i] = 1'b1;
            end
          end else begin
            m_held[i] = 0;
          end
        end
        m_pin_d2 = m_pin_d1;
        m_pin_d1 = button_in;
        if (avs_write && avs_address == 2'd2) m_mask = avs_writedata[3:0];
        if (avs_write && avs_address == 2'd3) m_edge = m_edge & ~avs_writedata[3:0];
        m_edge  = m_edge | presses;
        irq_exp = |(old_edge & old_mask);
      end
    end
  end

  // ---------------- monitor ----------------
  logic [31:0] last_rd = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        last_rd = '0;
      end else begin
        if (rd_pend) begin
          if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_empty: read seen with no expectation at %0t", $time);
          end else begin
            last_rd = exp_q.pop_front();
          end
        end
        chk("readdata", avs_readdata, last_rd);
        chk("irq", {31'd0, irq}, {31'd0, irq_exp});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd_const(input logic [1:0] a, input logic [31:0] v);
    avs_address = a;
    avs_read    = 1'b1;
    const_valid = 1'b1;
    const_val   = v;
    @(negedge clk);
    avs_read    = 1'b0;
    const_valid = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    avs_address   = a;
    avs_write     = 1'b1;
    avs_writedata = v;
    @(negedge clk);
    avs_write     = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    button_in = REL;
    avs_address = '0;
    avs_read = 1'b0;
    avs_write = 1'b0;
    avs_writedata = '0;
    cyc(3);
    rst = 1'b0;
    chk("reset_readdata", avs_readdata, 32'd0);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    rd_const(2'd0, 32'd0);
    rd_const(2'd3, 32'd0);
    cyc(12);
    rd_const(2'd3, 32'd0);
    rd_const(2'd1, 32'd0);

    // Clean press on bit0: accepted exactly 10 edges after the pin change.
    button_in = 4'hE;
    for (int j = 1; j <= 12; j++) rd_const(2'd0, (j >= 11) ? 32'h1 : 32'h0);
    rd_const(2'd3, 32'h1);

    // Release sets nothing; then clear.
    button_in = REL;
    cyc(15);
    rd_const(2'd3, 32'h1);
    wr(2'd3, 32'hF);
    rd_const(2'd3, 32'h0);

    // Bounce on bit1 (5-cycle segments never survive), then hold low.
    for (int k = 0; k < 8; k++) begin
      button_in = (k % 2 == 0) ? 4'hD : 4'hF;
      cyc(5);
    end
    button_in = 4'hD;
    for (int j = 1; j <= 12; j++) rd_const(2'd3, (j >= 11) ? 32'h2 : 32'h0);
    rd_const(2'd0, 32'h2);

    // irq: mask bit0, press bit0, clear, then a masked-off press on bit2.
    wr(2'd3, 32'hF);
    wr(2'd2, 32'h1);
    rd_const(2'd2, 32'h1);
    button_in = 4'hC;
    cyc(10);
    chk("irq_before_capture", {31'd0, irq}, 32'd0);
    cyc(1);
    chk("irq_after_capture", {31'd0, irq}, 32'd1);
    wr(2'd3, 32'h1);
    chk("irq_on_clear_edge", {31'd0, irq}, 32'd1);
    cyc(1);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    button_in = 4'h8;
    cyc(15);
    chk("irq_masked_press", {31'd0, irq}, 32'd0);
    rd_const(2'd3, 32'h4);

    // Set/clear collision on bit2.
    button_in = REL;
    cyc(15);
    wr(2'd3, 32'hF);
    rd_const(2'd3, 32'h0);
    button_in = 4'hB;
    cyc(9);
    wr(2'd3, 32'h4);
    rd_const(2'd3, 32'h4);

    // Direction and data registers ignore writes; read+write returns old data.
    wr(2'd1, 32'hFFFF_FFFF);
    rd_const(2'd1, 32'h0);
    wr(2'd0, 32'hFFFF_FFFF);
    rd_const(2'd0, 32'h4);
    avs_address = 2'd2; avs_read = 1'b1; avs_write = 1'b1; avs_writedata = 32'h6;
    const_valid = 1'b1; const_val = 32'h1;
    cyc(1);
    avs_read = 1'b0; avs_write = 1'b0; const_valid = 1'b0;
    rd_const(2'd2, 32'h6);

    // Reset in the middle of a debounce on bit3.
    button_in = REL;
    cyc(15);
    button_in = 4'h7;
    cyc(5);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    for (int j = 1; j <= 12; j++) rd_const(2'd3, (j >= 11) ? 32'h8 : 32'h0);
    rd_const(2'd1, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 11) == 0) button_in[$urandom_range(0, 3)] ^= 1'b1;
      avs_address   = 2'($urandom_range(0, 3));
      avs_read      = ($urandom_range(0, 1) == 1);
      avs_write     = ($urandom_range(0, 5) == 0);
      avs_writedata = $urandom;
      cyc(1);
    end
    avs_read  = 1'b0;
    avs_write = 1'b0;
    cyc(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
